mpu_store_collector: RTL and testbench



---
 rtl/mpu_store_collector_if.sv | 30 +++
 rtl/mpu_store_collector.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mpu_store_collector.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpu_store_collector_if.sv
// Store-stage memory-side stream bundle.
//   mem_store_en_in      : element valid
//   mem_store_element_in : element data (FPBITS+1 bits)
//   mem_m_store_size_in  : rows of the matrix being streamed
//   mem_n_store_size_in  : columns of the matrix being streamed
// master = store stage (drives the stream), slave = collector (consumes it).
interface mpu_store_collector_if #(
  parameter int unsigned FPBITS = 31,
  parameter int unsigned MBITS  = 2,
  parameter int unsigned NBITS  = 2
);
  logic              mem_store_en_in;
  logic [FPBITS:0]   mem_store_element_in;
  logic [MBITS:0]    mem_m_store_size_in;
  logic [NBITS:0]    mem_n_store_size_in;

  modport master (
    output mem_store_en_in,
    output mem_store_element_in,
    output mem_m_store_size_in,
    output mem_n_store_size_in
  );

  modport slave (
    input  mem_store_en_in,
    input  mem_store_element_in,
    input  mem_m_store_size_in,
    input  mem_n_store_size_in
  );
endinterface

// File: rtl/mpu_store_collector.sv
// mpu_store_collector
// Consumes the MPU store-stage element stream into a result buffer, checking
// stream length and continuity against the announced M x N size. Signals a
// one-cycle done pulse on success or a sticky error on any fault, and offers a
// registered flat row-major readback port.
//
// Ports:
//   clk                : rising-edge clock
//   rst                : asynchronous reset, active-low
//   collect_en_in      : arm request (sampled in IDLE only)
//   store_if           : store-stage stream (slave modport)
//   rd_addr_in         : flat readback index
//   rd_element_out     : buffer[rd_addr_in], registered; 0 when out of range
//   rd_m_out/rd_n_out  : M/N latched by the last collection
//   element_count_out  : elements captured in the current/last collection
//   collect_busy_out   : high in ARMED or COLLECT
//   collect_done_out   : one-cycle success pulse
//   collect_error_out  : sticky error, cleared on the next arm
//
// Build option: define MPU_COLLECT_TIMEOUT_EN to abort an ARMED wait after
// TIMEOUT_CYCLES edges without a stream element.
module mpu_store_collector #(
  parameter int unsigned FPBITS         = 31,
  parameter int unsigned MBITS          = 2,
  parameter int unsigned NBITS          = 2,
  parameter int unsigned NUM_ELEMENTS   = 9,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              collect_en_in,
  mpu_store_collector_if.slave              store_if,
  input  logic [$clog2(NUM_ELEMENTS)-1:0]   rd_addr_in,
  output logic [FPBITS:0]                   rd_element_out,
  output logic [MBITS:0]                    rd_m_out,
  output logic [NBITS:0]                    rd_n_out,
  output logic [$clog2(NUM_ELEMENTS+1)-1:0] element_count_out,
  output logic                              collect_busy_out,
  output logic                              collect_done_out,
  output logic                              collect_error_out
);

  localparam int unsigned AW = $clog2(NUM_ELEMENTS);
  localparam int unsigned CW = $clog2(NUM_ELEMENTS + 1);
  localparam int unsigned EW = MBITS + NBITS + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_COLLECT
  } state_t;

  state_t state_q, state_d;

  logic [FPBITS:0] buffer_q [NUM_ELEMENTS];
  logic [FPBITS:0] rd_element_q;
  logic [MBITS:0]  m_q;
  logic [NBITS:0]  n_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   exp_q;
  logic            done_q;
  logic            error_q;

  // Stream-side views
  logic            st_en;
  logic [FPBITS:0] st_elem;
  logic [MBITS:0]  st_m;
  logic [NBITS:0]  st_n;

  assign st_en   = store_if.mem_store_en_in;
  assign st_elem = store_if.mem_store_element_in;
  assign st_m    = store_if.mem_m_store_size_in;
  assign st_n    = store_if.mem_n_store_size_in;

  // Full-width product: no size combination can wrap.
  logic [EW-1:0] expected_full;
  logic          size_bad;
  logic          size_changed;
  logic [CW-1:0] count_inc;

  assign expected_full = EW'(st_m) * EW'(st_n);
  assign size_bad      = (expected_full == '0) ||
                         (32'(expected_full) > NUM_ELEMENTS);
  assign size_changed  = (st_m != m_q) || (st_n != n_q);
  assign count_inc     = count_q + CW'(1);

  // Decoded per-cycle events
  logic busy;
  logic arm;
  logic first_cap;
  logic first_bad;
  logic next_cap;
  logic last;
  logic stream_fault;
  logic timeout_hit;

  // ---------------------------------------------------------------------------
  // Optional armed-wait timeout
  // ---------------------------------------------------------------------------
`ifdef MPU_COLLECT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else if (arm) begin
      tmo_q <= '0;
    end else if ((state_q == S_ARMED) && !st_en) begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  // Fires on the TIMEOUT_CYCLES-th idle edge after entering ARMED.
  assign timeout_hit = (state_q == S_ARMED) && !st_en &&
                       (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  // ARMED waits indefinitely; the parameter only matters with the timeout built in.
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (first_bad || timeout_hit) begin
          state_d = S_IDLE;
        end else if (first_cap) begin
          state_d = last ? S_IDLE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (stream_fault || (next_cap && last)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    busy         = (state_q != S_IDLE);
    arm          = 1'b0;
    first_cap    = 1'b0;
    first_bad    = 1'b0;
    next_cap     = 1'b0;
    last         = 1'b0;
    stream_fault = 1'b0;
    case (state_q)
      S_IDLE: begin
        arm = collect_en_in;
      end
      S_ARMED: begin
        if (st_en) begin
          if (size_bad) begin
            first_bad = 1'b1;
          end else begin
            first_cap = 1'b1;
            last      = (expected_full == EW'(1));
          end
        end
      end
      S_COLLECT: begin
        // A gap or a size change aborts before the element is written.
        if (!st_en || size_changed) begin
          stream_fault = 1'b1;
        end else begin
          next_cap = 1'b1;
          last     = (count_inc == exp_q);
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Capture datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
        buffer_q[i] <= '0;
      end
      m_q     <= '0;
      n_q     <= '0;
      count_q <= '0;
      exp_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= (first_cap || next_cap) && last;

      if (arm) begin
        count_q <= '0;
        error_q <= 1'b0;
      end

      // Size is latched on the first element even when it is rejected,
      // so the readback shows what the store stage announced.
      if (first_cap || first_bad) begin
        m_q   <= st_m;
        n_q   <= st_n;
        exp_q <= CW'(expected_full);
      end

      if (first_bad || stream_fault || timeout_hit) begin
        error_q <= 1'b1;
      end

      if (first_cap) begin
        buffer_q[0] <= st_elem;
        count_q     <= CW'(1);
      end

      if (next_cap) begin
        buffer_q[AW'(count_q)] <= st_elem;
        count_q                <= count_inc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered readback (same-cycle write returns the old entry)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_element_q <= '0;
    end else if (32'(rd_addr_in) < NUM_ELEMENTS) begin
      rd_element_q <= buffer_q[rd_addr_in];
    end else begin
      rd_element_q <= '0;
    end
  end

  assign rd_element_out    = rd_element_q;
  assign rd_m_out          = m_q;
  assign rd_n_out          = n_q;
  assign element_count_out = count_q;
  assign collect_busy_out  = busy;
  assign collect_done_out  = done_q;
  assign collect_error_out = error_q;

endmodule

// File: tb/tb_mpu_store_collector.sv
module tb_mpu_store_collector;

  localparam int unsigned NE = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        collect_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [31:0] rd_element_out;
  logic [2:0]  rd_m_out;
  logic [2:0]  rd_n_out;
  logic [3:0]  element_count_out;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int fails  = 0;

  logic [31:0] model_mem [NE];
  logic [31:0] sb_q [$];
  logic [31:0] exp_v;

  logic [31:0] vec3 [NE] = '{32'h3f800000, 32'h424951ec, 32'hc0200000,
                             32'h3e000000, 32'hbeaaaa9f, 32'h4e932c06,
                             32'h00000000, 32'hb6a7c5ac, 32'hd01326bc};
  logic [31:0] vec2 [4]  = '{32'h40400000, 32'hc1200000, 32'h3f000000,
                             32'h3e000000};

  mpu_store_collector_if #(.FPBITS(31), .MBITS(2), .NBITS(2)) store_if ();

  mpu_store_collector #(
    .FPBITS(31), .MBITS(2), .NBITS(2), .NUM_ELEMENTS(NE), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .collect_en_in     (collect_en),
    .store_if          (store_if),
    .rd_addr_in        (rd_addr),
    .rd_element_out    (rd_element_out),
    .rd_m_out          (rd_m_out),
    .rd_n_out          (rd_n_out),
    .element_count_out (element_count_out),
    .collect_busy_out  (busy),
    .collect_done_out  (done),
    .collect_error_out (error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    store_if.mem_store_en_in      = 1'b0;
    store_if.mem_store_element_in = '0;
    store_if.mem_m_store_size_in  = '0;
    store_if.mem_n_store_size_in  = '0;
  endtask

  task automatic drive_elem(input logic [31:0] d, input logic [2:0] m, input logic [2:0] n);
    store_if.mem_store_en_in      = 1'b1;
    store_if.mem_store_element_in = d;
    store_if.mem_m_store_size_in  = m;
    store_if.mem_n_store_size_in  = n;
  endtask

  task automatic arm();
    collect_en = 1'b1;
    tick();
    collect_en = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (rd_element_out !== 32'h0) begin fails++; $display("FAIL reset_rd_element got %h want 0", rd_element_out); end
    checks++; if (rd_m_out !== 3'd0) begin fails++; $display("FAIL reset_rd_m got %0d want 0", rd_m_out); end
    checks++; if (rd_n_out !== 3'd0) begin fails++; $display("FAIL reset_rd_n got %0d want 0", rd_n_out); end
    checks++; if (element_count_out !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", element_count_out); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error got %b want 0", error); end
    rst = 1'b1;
    for (int unsigned i = 0; i < NE; i++) model_mem[i] = '0;
    tick();
  endtask

  task automatic test_capture_3x3();
    int done_seen;
    done_seen = 0;
    arm();
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL c33_busy_after_arm got %b want 1", busy); end
    for (int unsigned i = 0; i < NE; i++) begin
      drive_elem(vec3[i], 3'd3, 3'd3);
      model_mem[i] = vec3[i];
      tick();
      if (done === 1'b1) done_seen++;
      checks++; if (element_count_out !== 4'(i + 1)) begin fails++; $display("FAIL c33_count[%0d] got %0d want %0d", i, element_count_out, i + 1); end
    end
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL c33_done got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL c33_busy_end got %b want 0", busy); end
    drive_idle();
    tick();
    if (done === 1'b1) done_seen++;
    checks++; if (done_seen != 1) begin fails++; $display("FAIL c33_done_pulses got %0d want 1", done_seen); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL c33_error got %b want 0", error); end
    checks++; if (rd_m_out !== 3'd3) begin fails++; $display("FAIL c33_rd_m got %0d want 3", rd_m_out); end
    checks++; if (rd_n_out !== 3'd3) begin fails++; $display("FAIL c33_rd_n got %0d want 3", rd_n_out); end
    // readback 0..9 plus 15; out-of-range indices read as 0
    for (int unsigned i = 0; i <= NE + 1; i++) begin
      rd_addr = (i == NE + 1) ? 4'd15 : 4'(i);
      sb_q.push_back((int'(rd_addr) < NE) ? model_mem[rd_addr] : 32'h0);
      tick();
      exp_v = sb_q.pop_front();
      checks++; if (rd_element_out !== exp_v) begin fails++; $display("FAIL c33_readback[%0d] got %h want %h", rd_addr, rd_element_out, exp_v); end
    end
    rd_addr = 4'd4;
    tick();
    checks++; if (rd_element_out !== 32'hbeaaaa9f) begin fails++; $display("FAIL c33_index4 got %h want beaaaa9f", rd_element_out); end
  endtask

  task automatic test_capture_2x2();
    arm();
    rd_addr = 4'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      drive_elem(vec2[i], 3'd2, 3'd2);
      // read of index 0 while it is being written returns the old entry
      if (i == 0) sb_q.push_back(model_mem[0]);
      model_mem[i] = vec2[i];
      tick();
      if (i == 0) begin
        exp_v = sb_q.pop_front();
        checks++; if (rd_element_out !== exp_v) begin fails++; $display("FAIL c22_rw_collision got %h want %h", rd_element_out, exp_v); end
      end
      if (i < 3) begin
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL c22_early_done[%0d] got %b want 0", i, done); end
      end
    end
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL c22_done got %b want 1", done); end
    drive_idle();
    tick();
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL c22_done_drop got %b want 0", done); end
    for (int unsigned i = 0; i < 4; i++) begin
      rd_addr = 4'(i);
      sb_q.push_back(model_mem[i]);
      tick();
      exp_v = sb_q.pop_front();
      checks++; if (rd_element_out !== exp_v) begin fails++; $display("FAIL c22_readback[%0d] got %h want %h", i, rd_element_out, exp_v); end
    end
    checks++; if (rd_element_out !== 32'h3e000000) begin fails++; $display("FAIL c22_index3 got %h want 3e000000", rd_element_out); end
  endtask

  task automatic test_gap();
    arm();
    for (int unsigned i = 0; i < 5; i++) begin
      drive_elem(32'h10000000 + 32'(i), 3'd3, 3'd3);
      model_mem[i] = 32'h10000000 + 32'(i);
      tick();
    end
    drive_idle();
    tick();
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL gap_error got %b want 1", error); end
    checks++; if (element_count_out !== 4'd5) begin fails++; $display("FAIL gap_count got %0d want 5", element_count_out); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL gap_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL gap_done got %b want 0", done); end
    tick();
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL gap_error_sticky got %b want 1", error); end
    for (int unsigned i = 0; i < NE; i++) begin
      rd_addr = 4'(i);
      sb_q.push_back(model_mem[i]);
      tick();
      exp_v = sb_q.pop_front();
      checks++; if (rd_element_out !== exp_v) begin fails++; $display("FAIL gap_readback[%0d] got %h want %h", i, rd_element_out, exp_v); end
    end
  endtask

  task automatic test_oversize();
    arm();
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL over_arm_clears_error got %b want 0", error); end
    drive_elem(32'hdeadbeef, 3'd3, 3'd4);
    tick();
    drive_idle();
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL over_error got %b want 1", error); end
    checks++; if (element_count_out !== 4'd0) begin fails++; $display("FAIL over_count got %0d want 0", element_count_out); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL over_busy got %b want 0", busy); end
    checks++; if (rd_n_out !== 3'd4) begin fails++; $display("FAIL over_rd_n got %0d want 4", rd_n_out); end
    rd_addr = 4'd0;
    sb_q.push_back(model_mem[0]);
    tick();
    exp_v = sb_q.pop_front();
    checks++; if (rd_element_out !== exp_v) begin fails++; $display("FAIL over_buffer0 got %h want %h", rd_element_out, exp_v); end
    // zero-size matrix is rejected the same way
    arm();
    drive_elem(32'hcafef00d, 3'd0, 3'd3);
    tick();
    drive_idle();
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL zero_size_error got %b want 1", error); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_size_busy got %b want 0", busy); end
  endtask

  task automatic test_size_change();
    arm();
    for (int unsigned i = 0; i < 2; i++) begin
      drive_elem(32'h20000000 + 32'(i), 3'd3, 3'd3);
      model_mem[i] = 32'h20000000 + 32'(i);
      tick();
    end
    drive_elem(32'h2badbad0, 3'd3, 3'd2);
    tick();
    drive_idle();
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL chg_error got %b want 1", error); end
    checks++; if (element_count_out !== 4'd2) begin fails++; $display("FAIL chg_count got %0d want 2", element_count_out); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL chg_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL chg_done got %b want 0", done); end
    for (int unsigned i = 0; i < 3; i++) begin
      rd_addr = 4'(i);
      sb_q.push_back(model_mem[i]);
      tick();
      exp_v = sb_q.pop_front();
      checks++; if (rd_element_out !== exp_v) begin fails++; $display("FAIL chg_readback[%0d] got %h want %h", i, rd_element_out, exp_v); end
    end
  endtask

  task automatic test_reset_mid();
    arm();
    for (int unsigned i = 0; i < 3; i++) begin
      drive_elem(vec3[i], 3'd3, 3'd3);
      tick();
    end
    rst = 1'b0;
    #1;
    checks++; if (rd_element_out !== 32'h0) begin fails++; $display("FAIL rstmid_rd_element got %h want 0", rd_element_out); end
    checks++; if (rd_m_out !== 3'd0 || rd_n_out !== 3'd0) begin fails++; $display("FAIL rstmid_rd_mn got %0d/%0d want 0/0", rd_m_out, rd_n_out); end
    checks++; if (element_count_out !== 4'd0) begin fails++; $display("FAIL rstmid_count got %0d want 0", element_count_out); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL rstmid_done_error got %b/%b want 0/0", done, error); end
    drive_idle();
    for (int unsigned i = 0; i < NE; i++) model_mem[i] = '0;
    tick();
    rst = 1'b1;
    rd_addr = 4'd1;
    sb_q.push_back(model_mem[1]);
    tick();
    exp_v = sb_q.pop_front();
    checks++; if (rd_element_out !== exp_v) begin fails++; $display("FAIL rstmid_buffer_cleared got %h want %h", rd_element_out, exp_v); end
  endtask

  task automatic test_timeout();
    drive_idle();
    arm();
`ifdef MPU_COLLECT_TIMEOUT_EN
    repeat (63) tick();
    checks++; if (busy !== 1'b1 || error !== 1'b0) begin fails++; $display("FAIL tmo_early busy/error got %b/%b want 1/0", busy, error); end
    tick();
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL tmo_error got %b want 1", error); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL tmo_busy got %b want 0", busy); end
`else
    repeat (200) tick();
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL notmo_busy got %b want 1", busy); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL notmo_error got %b want 0", error); end
`endif
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_capture_3x3();
    test_capture_2x2();
    test_gap();
    test_oversize();
    test_size_change();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
